reqack_monitor_mc: RTL and testbench
====================================

Name: reqack_monitor_mc

Overview:
Synthesizable, parametrised multi-channel protocol monitor for the req/ack/done/interrupt handshake. Each channel runs an independent FSM with these checks:
- bounded ack window after req
- done exactly one cycle after ack
- no ack coincident with done
- interrupt within a bounded window after done
Violations are reported as sticky per-channel flags, and clean transactions are counted. It sits beside the DUT in the testbench or emulation harness, in place of assertion-only checking.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
MIN_ACK, 1, earliest legal ack offset in cycles after req (>=1)
MAX_ACK, 5, latest legal ack offset after req (>=MIN_ACK)
INTR_WIN, 3, interrupt legal at offset 0..INTR_WIN cycles after done
CNT_W, 8, width of per-channel pass counter

Ports:
clk  input  1  sampling clock, rising edge
reset_n  input  1  asynchronous active-low reset
req  input  NUM_CH  per-channel request
ack  input  NUM_CH  per-channel acknowledge
done  input  NUM_CH  per-channel done
intrpt  input  NUM_CH  per-channel interrupt
clr_err  input  1  synchronous clear of all sticky error flags
err_ack  output  NUM_CH  sticky: ack early or missing
err_done  output  NUM_CH  sticky: done not exactly 1 cycle after ack
err_ackdone  output  NUM_CH  sticky: ack and done high in the same cycle
err_intr  output  NUM_CH  sticky: no intrpt within window after done
err_any  output  1  OR of all sticky flags (combinational from registers)
pass_cnt  output  NUM_CH*CNT_W  per-channel clean-transaction count; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (reset_n=0, asynchronous): all FSMs go to IDLE; all counters, flags and pass_cnt are 0; err_any=0. Release is synchronous to clk.
- Per-channel state: IDLE, WAIT_ACK, WAIT_DONE, WAIT_INTR. Each channel also holds an offset counter (width clog2(max(MAX_ACK,INTR_WIN)+1)) and a txn_bad bit.
- IDLE: req=1 at edge t0 -> WAIT_ACK, offset=1, txn_bad=0. All other inputs are ignored, except the ack&done check.
- WAIT_ACK, sampled each edge at the current offset:
  - ack=1 and offset<MIN_ACK -> set err_ack, go to IDLE.
  - ack=1 and offset>=MIN_ACK -> WAIT_DONE.
  - ack=0 and offset==MAX_ACK -> set err_ack, go to IDLE.
  - otherwise offset+1.
- WAIT_DONE: lasts exactly one sample.
  - done=1 -> evaluate intrpt in the same cycle (offset 0): if intrpt=1 the transaction completes; else go to WAIT_INTR with offset=1.
  - done=0 -> set err_done, go to IDLE.
- WAIT_INTR:
  - intrpt=1 -> complete, go to IDLE.
  - intrpt=0 and offset==INTR_WIN -> set err_intr, set txn_bad, go to IDLE.
  - otherwise offset+1.
  - With INTR_WIN=0, only the offset-0 check in WAIT_DONE applies.
- Completion: pass_cnt[i] increments only if txn_bad=0. It saturates at 2^CNT_W-1 and never wraps.
- ack&done check: ack[i]&done[i]=1 in any state -> set err_ackdone, set txn_bad. The FSM continues normally; the transaction may still complete but is not counted.
- req while not IDLE is ignored (no overlapping transactions). On completion or error the FSM returns to IDLE; a req sampled in that same cycle is not accepted, and req must be re-sampled in IDLE.
- Flag timing: a violation sampled at edge t sets its flag register at t, visible after t. Flags stay set until clr_err=1 or reset.
- clr_err at the same edge as a new violation: the set wins for that flag. Other flags clear.
- Channels are fully independent; there are no cross-channel interactions.

Test Plan:
1. ch0: req@t0, ack@t3, done@t4, intrpt@t6 -> no flags; pass_cnt[0]=1; other channels' counts remain 0.
2. ch1: req@t0, ack low t1..t5 -> err_ack[1]=1 after edge t5, err_any=1. clr_err@t8 -> all flags 0 after t8.
3. ch2: req@t0, ack@t1, done=0@t2 -> err_done[2]=1 after t2. Repeat with MIN_ACK=2 and ack@t1 -> err_ack[2]=1.
4. ch3: req@t0, ack@t2, done&ack@t3, intrpt@t3 -> err_ackdone[3]=1; FSM completes; pass_cnt[3] stays 0.
5. ch0: clean req/ack, done@t, intrpt low t..t+3 -> err_intr[0]=1 after edge t+3. Repeat with intrpt@t+3 -> pass.
6. reset_n low mid-WAIT_ACK on all channels -> all outputs 0 without a clock edge. Separately, with CNT_W=4, 20 clean transactions -> pass_cnt=15 (saturated).

Source files
------------

// File: rtl/reqack_monitor_mc.sv
// rtl/reqack_monitor_mc.sv - multi-channel req/ack/done/interrupt handshake protocol monitor
//
// Purpose: watches NUM_CH independent req/ack/done/intrpt handshakes. Each
// channel has its own FSM, which checks four rules:
//   - ack arrives within the MIN_ACK..MAX_ACK window after req
//   - done arrives exactly one cycle after ack
//   - ack and done are never high together
//   - intrpt arrives within 0..INTR_WIN cycles after done
// Rule violations set sticky per-channel flags. Clean transactions are
// counted in a saturating per-channel counter.
//
// Ports:
//   clk          sampling clock, rising edge
//   reset_n      asynchronous active-low reset
//   req/ack/done/intrpt [NUM_CH]  per-channel handshake inputs
//   clr_err      synchronous clear of all sticky flags (a same-edge set wins)
//   err_ack      sticky: ack early or missing
//   err_done     sticky: done not exactly one cycle after ack
//   err_ackdone  sticky: ack and done high in the same cycle
//   err_intr     sticky: no intrpt within the window after done
//   err_any      OR of every sticky flag
//   pass_cnt     clean-transaction counts, channel i at [i*CNT_W +: CNT_W]
module reqack_monitor_mc #(
    parameter int NUM_CH   = 4,
    parameter int MIN_ACK  = 1,
    parameter int MAX_ACK  = 5,
    parameter int INTR_WIN = 3,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       ack,
    input  logic [NUM_CH-1:0]       done,
    input  logic [NUM_CH-1:0]       intrpt,
    input  logic                    clr_err,
    output logic [NUM_CH-1:0]       err_ack,
    output logic [NUM_CH-1:0]       err_done,
    output logic [NUM_CH-1:0]       err_ackdone,
    output logic [NUM_CH-1:0]       err_intr,
    output logic                    err_any,
    output logic [NUM_CH*CNT_W-1:0] pass_cnt
);

    // One offset counter serves both the ack window and the interrupt window.
    localparam int OFF_MAX = (MAX_ACK > INTR_WIN) ? MAX_ACK : INTR_WIN;
    localparam int OFF_W   = $clog2(OFF_MAX + 1);

    localparam logic [OFF_W-1:0] L_ONE      = OFF_W'(1);
    localparam logic [OFF_W-1:0] L_MIN_ACK  = OFF_W'(MIN_ACK);
    localparam logic [OFF_W-1:0] L_MAX_ACK  = OFF_W'(MAX_ACK);
    localparam logic [OFF_W-1:0] L_INTR_WIN = OFF_W'(INTR_WIN);
    localparam logic [CNT_W-1:0] L_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACK  = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_WAIT_INTR = 2'd3
    } state_t;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           r_state;
        logic [OFF_W-1:0] r_off;
        logic             r_txn_bad;
        logic             r_err_ack;
        logic             r_err_done;
        logic             r_err_ackdone;
        logic             r_err_intr;
        logic [CNT_W-1:0] r_pass;

        logic w_ackdone;
        logic w_clean;
        logic w_cnt_full;

        assign w_ackdone  = ack[g] & done[g];
        // A collision in the completing cycle itself also disqualifies the count.
        assign w_clean    = ~(r_txn_bad | w_ackdone);
        assign w_cnt_full = (r_pass == {CNT_W{1'b1}});

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state       <= S_IDLE;
                r_off         <= '0;
                r_txn_bad     <= 1'b0;
                r_err_ack     <= 1'b0;
                r_err_done    <= 1'b0;
                r_err_ackdone <= 1'b0;
                r_err_intr    <= 1'b0;
                r_pass        <= '0;
            end else begin
                // Clear first; any set later in this block overrides it for
                // its own flag, so a same-edge violation is never lost.
                if (clr_err) begin
                    r_err_ack     <= 1'b0;
                    r_err_done    <= 1'b0;
                    r_err_ackdone <= 1'b0;
                    r_err_intr    <= 1'b0;
                end

                // The collision check runs in every state and never steers the FSM.
                if (w_ackdone) begin
                    r_err_ackdone <= 1'b1;
                end
                r_txn_bad <= r_txn_bad | w_ackdone;

                case (r_state)
                    S_IDLE: begin
                        if (req[g]) begin
                            r_state   <= S_WAIT_ACK;
                            r_off     <= L_ONE;
                            r_txn_bad <= w_ackdone;
                        end
                    end

                    S_WAIT_ACK: begin
                        if (ack[g]) begin
                            if (r_off < L_MIN_ACK) begin
                                r_err_ack <= 1'b1;
                                r_state   <= S_IDLE;
                            end else begin
                                r_state   <= S_WAIT_DONE;
                            end
                        end else if (r_off == L_MAX_ACK) begin
                            r_err_ack <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_off <= r_off + L_ONE;
                        end
                    end

                    // Single-sample state: done must be present on the cycle after ack.
                    // Interrupt offset 0 is checked here, alongside done.
                    S_WAIT_DONE: begin
                        if (!done[g]) begin
                            r_err_done <= 1'b1;
                            r_state    <= S_IDLE;
                        end else if (intrpt[g]) begin
                            r_state <= S_IDLE;
                            if (w_clean && !w_cnt_full) begin
                                r_pass <= r_pass + L_CNT_ONE;
                            end
                        end else if (INTR_WIN == 0) begin
                            r_err_intr <= 1'b1;
                            r_txn_bad  <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT_INTR;
                            r_off   <= L_ONE;
                        end
                    end

                    S_WAIT_INTR: begin
                        if (intrpt[g]) begin
                            r_state <= S_IDLE;
                            if (w_clean && !w_cnt_full) begin
                                r_pass <= r_pass + L_CNT_ONE;
                            end
                        end else if (r_off == L_INTR_WIN) begin
                            r_err_intr <= 1'b1;
                            r_txn_bad  <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_off <= r_off + L_ONE;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end

        assign err_ack[g]                   = r_err_ack;
        assign err_done[g]                  = r_err_done;
        assign err_ackdone[g]               = r_err_ackdone;
        assign err_intr[g]                  = r_err_intr;
        assign pass_cnt[g*CNT_W +: CNT_W]   = r_pass;
    end

    assign err_any = |{err_ack, err_done, err_ackdone, err_intr};

endmodule

// File: tb/tb_reqack_monitor_mc.sv
// tb/tb_reqack_monitor_mc.sv - scoreboard bench for reqack_monitor_mc (two parameter sets)
module tb_reqack_monitor_mc;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req, ack, done, intrpt;
    logic       clr_err;

    logic [3:0]  a_ack, a_done, a_ad, a_intr;
    logic        a_any;
    logic [31:0] a_cnt;
    logic [3:0]  b_ack, b_done, b_ad, b_intr;
    logic        b_any;
    logic [15:0] b_cnt;

    always #5 clk = ~clk;

    reqack_monitor_mc #(.NUM_CH(4), .MIN_ACK(1), .MAX_ACK(5), .INTR_WIN(3), .CNT_W(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .req(req), .ack(ack), .done(done), .intrpt(intrpt),
        .clr_err(clr_err), .err_ack(a_ack), .err_done(a_done), .err_ackdone(a_ad),
        .err_intr(a_intr), .err_any(a_any), .pass_cnt(a_cnt)
    );

    reqack_monitor_mc #(.NUM_CH(4), .MIN_ACK(2), .MAX_ACK(4), .INTR_WIN(0), .CNT_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req), .ack(ack), .done(done), .intrpt(intrpt),
        .clr_err(clr_err), .err_ack(b_ack), .err_done(b_done), .err_ackdone(b_ad),
        .err_intr(b_intr), .err_any(b_any), .pass_cnt(b_cnt)
    );

    int n_chk = 0;
    int n_err = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: per channel, timestamps of req/ack/done of the open transaction
    int         mp_min[2] = '{1, 2};
    int         mp_max[2] = '{5, 4};
    int         mp_iw[2]  = '{3, 0};
    int         mp_sat[2] = '{255, 15};
    bit         m_open[2][4];
    int         m_treq[2][4], m_tack[2][4], m_tdone[2][4];
    bit         m_bad[2][4];
    logic [3:0] m_f[2][4];    // {intr, ackdone, done, ack}
    int         m_cnt[2][4];

    typedef struct {
        int          at_edge;
        logic [63:0] v0;
        logic [63:0] v1;
    } exp_t;
    exp_t expq[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_cnt, got, want);
        end
    endtask

    function automatic logic [63:0] act0();
        return {15'b0, a_ack, a_done, a_ad, a_intr, a_any, a_cnt};
    endfunction

    function automatic logic [63:0] act1();
        return {15'b0, b_ack, b_done, b_ad, b_intr, b_any, 16'b0, b_cnt};
    endfunction

    function automatic logic [63:0] pack_exp(input int m);
        logic [3:0]  fa, fd, fx, fi;
        logic [31:0] cv;
        cv = '0;
        for (int c = 0; c < 4; c++) begin
            fa[c] = m_f[m][c][0];
            fd[c] = m_f[m][c][1];
            fx[c] = m_f[m][c][2];
            fi[c] = m_f[m][c][3];
            if (m == 0) cv[c*8 +: 8] = 8'(m_cnt[0][c]);
            else        cv[c*4 +: 4] = 4'(m_cnt[1][c]);
        end
        return {15'b0, fa, fd, fx, fi, |{fa, fd, fx, fi}, cv};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 4; c++) begin
                m_open[m][c] = 1'b0;
                m_bad[m][c]  = 1'b0;
                m_f[m][c]    = 4'b0;
                m_cnt[m][c]  = 0;
            end
    endtask

    // Apply the handshake rules for the edge numbered e.
    task automatic model_step(input int e, input logic [3:0] rq, ak, dn, it, input logic cl);
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) begin
                logic [3:0] st;
                bit         ad;
                bit         fin;
                st  = 4'b0;
                fin = 1'b0;
                ad  = ak[c] & dn[c];
                st[2] = ad;
                if (!m_open[m][c]) begin
                    if (rq[c]) begin
                        m_open[m][c]  = 1'b1;
                        m_treq[m][c]  = e;
                        m_tack[m][c]  = -1;
                        m_tdone[m][c] = -1;
                        m_bad[m][c]   = ad;
                    end
                end else begin
                    m_bad[m][c] = m_bad[m][c] | ad;
                    if (m_tack[m][c] < 0) begin
                        if (ak[c]) begin
                            if (e - m_treq[m][c] < mp_min[m]) begin st[0] = 1'b1; m_open[m][c] = 1'b0; end
                            else m_tack[m][c] = e;
                        end else if (e - m_treq[m][c] == mp_max[m]) begin
                            st[0] = 1'b1; m_open[m][c] = 1'b0;
                        end
                    end else if (m_tdone[m][c] < 0) begin
                        if (!dn[c]) begin
                            st[1] = 1'b1; m_open[m][c] = 1'b0;
                        end else begin
                            m_tdone[m][c] = e;
                            if (it[c]) fin = 1'b1;
                            else if (mp_iw[m] == 0) begin st[3] = 1'b1; m_open[m][c] = 1'b0; end
                        end
                    end else begin
                        if (it[c]) fin = 1'b1;
                        else if (e - m_tdone[m][c] == mp_iw[m]) begin st[3] = 1'b1; m_open[m][c] = 1'b0; end
                    end
                end
                if (fin) begin
                    m_open[m][c] = 1'b0;
                    if (!m_bad[m][c] && m_cnt[m][c] < mp_sat[m]) m_cnt[m][c]++;
                end
                m_f[m][c] = (cl ? 4'b0 : m_f[m][c]) | st;
            end
        end
    endtask

    // Inputs change on the falling edge; they are sampled at the next rising edge.
    task automatic drive(input logic [3:0] rq, ak, dn, it, input logic cl);
        exp_t e;
        @(negedge clk);
        req = rq; ack = ak; done = dn; intrpt = it; clr_err = cl;
        model_step(edge_cnt + 1, rq, ak, dn, it, cl);
        e.at_edge = edge_cnt + 1;
        e.v0 = pack_exp(0);
        e.v1 = pack_exp(1);
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rbits(input int pct);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 99) < pct);
        return r;
    endfunction

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (expq.size() > 0 && expq[0].at_edge <= edge_cnt) begin
                e = expq.pop_front();
                chk("sb_dut0", act0(), e.v0);
                chk("sb_dut1", act1(), e.v1);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        req = 4'h0; ack = 4'h0; done = 4'h0; intrpt = 4'h0; clr_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut0", act0(), 64'h0);
        chk("reset_dut1", act1(), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: ch0 clean, ack at offset 3, intrpt 2 cycles after done
        drive(4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        idle(2);
        drive(4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
        drive(4'h0, 4'h0, 4'h1, 4'h0, 1'b0);
        idle(1);
        drive(4'h0, 4'h0, 4'h0, 4'h1, 1'b0);
        after_edge();
        chk("t1_cnt0", 64'(a_cnt), 64'h1);
        chk("t1_flags", 64'({a_ack, a_done, a_ad, a_intr, a_any}), 64'h0);

        // 2: ch1 ack missing, then clr_err
        drive(4'h2, 4'h0, 4'h0, 4'h0, 1'b0);
        idle(4);
        after_edge();
        chk("t2_noack_early", 64'(a_ack[1]), 64'h0);
        idle(1);
        after_edge();
        chk("t2_noack", 64'({a_ack[1], a_any}), 64'h3);
        idle(2);
        drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        after_edge();
        chk("t2_clr", 64'({a_any, b_any}), 64'h0);

        // 3: ch2 ack at offset 1, no done; MIN_ACK=2 instance sees an early ack
        drive(4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
        drive(4'h0, 4'h4, 4'h0, 4'h0, 1'b0);
        drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        after_edge();
        chk("t3_done", 64'({a_done, a_ack}), 64'h40);
        chk("t3_early_ack", 64'({b_ack, b_done}), 64'h40);

        // 4: ch3 ack+done collision with intrpt on the done cycle
        drive(4'h8, 4'h0, 4'h0, 4'h0, 1'b0);
        idle(1);
        drive(4'h0, 4'h8, 4'h0, 4'h0, 1'b0);
        drive(4'h0, 4'h8, 4'h8, 4'h8, 1'b0);
        after_edge();
        chk("t4_ackdone", 64'({a_ad, a_done[3]}), 64'h10);
        chk("t4_cnt3", 64'(a_cnt[31:24]), 64'h0);

        // 5: ch0 interrupt window timeout, then interrupt at the last legal offset
        drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        drive(4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        idle(1);
        drive(4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
        drive(4'h0, 4'h0, 4'h1, 4'h0, 1'b0);
        idle(2);
        after_edge();
        chk("t5_intr_pending", 64'(a_intr[0]), 64'h0);
        idle(1);
        after_edge();
        chk("t5_intr_timeout", 64'(a_intr[0]), 64'h1);
        drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        drive(4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        idle(1);
        drive(4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
        drive(4'h0, 4'h0, 4'h1, 4'h0, 1'b0);
        idle(2);
        drive(4'h0, 4'h0, 4'h0, 4'h1, 1'b0);
        after_edge();
        chk("t5_intr_last", 64'({a_intr[0], a_cnt[7:0]}), 64'h002);

        // 6b: 20 clean transactions on ch0; the 4-bit counter saturates
        for (int k = 0; k < 20; k++) begin
            drive(4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
            idle(1);
            drive(4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
            drive(4'h0, 4'h0, 4'h1, 4'h1, 1'b0);
        end
        after_edge();
        chk("sat_cnt4", 64'(b_cnt), 64'h000F);
        chk("cnt8", 64'(a_cnt), 64'h00000016);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            drive(rbits(30), rbits(35), rbits(35), rbits(45), ($urandom_range(0, 99) < 3));
        end

        // 6a: asynchronous reset in the middle of WAIT_ACK
        drive(4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        idle(1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_dut0", act0(), 64'h0);
        chk("async_rst_dut1", act1(), 64'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        drive(4'h3, 4'h0, 4'h0, 4'h0, 1'b0);
        idle(1);
        drive(4'h0, 4'h3, 4'h0, 4'h0, 1'b0);
        drive(4'h0, 4'h0, 4'h3, 4'h3, 1'b0);
        after_edge();
        chk("post_rst_cnt", 64'(a_cnt), 64'h00000101);
        idle(2);
        @(negedge clk);
        #1;
        chk("sb_drained", 64'(expq.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
